// File: rtl/idex_stage.sv
`default_nettype none
// ============================================================================
// Module   : idex_stage
// Brief    : ID/EX pipeline register with load-use hazard detection,
//            flush/hold handling and saturating stall/flush event counters.
// Revision : 1.0  initial release
// ============================================================================
module idex_stage (
  input  logic        clk,
  input  logic        rst,
  // ID stage
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [31:0] id_rdata1,
  input  logic [31:0] id_rdata2,
  input  logic [31:0] id_imm,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_MemtoReg,
  input  logic        id_ALUSrc,
  input  logic        id_RegDst,
  input  logic [1:0]  id_ALUOp,
  // pipeline control
  input  logic        flush,
  input  logic        hold,
  // ID/EX register
  output logic        IDEX_valid,
  output logic [4:0]  IDEX_Rs,
  output logic [4:0]  IDEX_Rt,
  output logic [4:0]  IDEX_Rd,
  output logic [31:0] IDEX_rdata1,
  output logic [31:0] IDEX_rdata2,
  output logic [31:0] IDEX_imm,
  output logic        IDEX_RegWrite,
  output logic        IDEX_MemRead,
  output logic        IDEX_MemWrite,
  output logic        IDEX_MemtoReg,
  output logic        IDEX_ALUSrc,
  output logic        IDEX_RegDst,
  output logic [1:0]  IDEX_ALUOp,
  // hazard / statistics
  output logic        stall,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic        regdst;
    logic [1:0]  aluop;
  } idex_t;

  idex_t       pipe_q, pipe_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        w_rs_hit;
  logic        w_rt_hit;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign w_rs_hit = id_uses_rs && (id_rs == pipe_q.rt);
  assign w_rt_hit = id_uses_rt && (id_rt == pipe_q.rt);
  assign stall    = !rst && !flush && !hold && id_valid && pipe_q.valid &&
                    pipe_q.memread && (pipe_q.rt != 5'd0) && (w_rs_hit || w_rt_hit);

  always_comb begin
    pipe_d = pipe_q;
    if (flush || (!hold && stall)) begin
      pipe_d = '0;
    end else if (!hold) begin
      pipe_d.valid    = id_valid;
      pipe_d.rs       = id_rs;
      pipe_d.rt       = id_rt;
      pipe_d.rd       = id_rd;
      pipe_d.rdata1   = id_rdata1;
      pipe_d.rdata2   = id_rdata2;
      pipe_d.imm      = id_imm;
      pipe_d.regwrite = id_valid && id_RegWrite;
      pipe_d.memread  = id_valid && id_MemRead;
      pipe_d.memwrite = id_valid && id_MemWrite;
      pipe_d.memtoreg = id_valid && id_MemtoReg;
      pipe_d.alusrc   = id_valid && id_ALUSrc;
      pipe_d.regdst   = id_valid && id_RegDst;
      pipe_d.aluop    = id_valid ? id_ALUOp : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      if (stall && (stall_cnt_q != C_CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush && (flush_cnt_q != C_CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign IDEX_valid    = pipe_q.valid;
  assign IDEX_Rs       = pipe_q.rs;
  assign IDEX_Rt       = pipe_q.rt;
  assign IDEX_Rd       = pipe_q.rd;
  assign IDEX_rdata1   = pipe_q.rdata1;
  assign IDEX_rdata2   = pipe_q.rdata2;
  assign IDEX_imm      = pipe_q.imm;
  assign IDEX_RegWrite = pipe_q.regwrite;
  assign IDEX_MemRead  = pipe_q.memread;
  assign IDEX_MemWrite = pipe_q.memwrite;
  assign IDEX_MemtoReg = pipe_q.memtoreg;
  assign IDEX_ALUSrc   = pipe_q.alusrc;
  assign IDEX_RegDst   = pipe_q.regdst;
  assign IDEX_ALUOp    = pipe_q.aluop;
  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_idex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_idex_stage
// Brief    : Directed self-checking bench for idex_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_idex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst;
  logic [1:0]  id_ALUOp;
  logic        flush, hold;
  logic        IDEX_valid;
  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic [31:0] IDEX_rdata1, IDEX_rdata2, IDEX_imm;
  logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_RegDst;
  logic [1:0]  IDEX_ALUOp;
  logic        stall;
  logic [15:0] stall_count, flush_count;

  int n_chk  = 0;
  int n_pass = 0;

  idex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
    .id_ALUOp(id_ALUOp), .flush(flush), .hold(hold),
    .IDEX_valid(IDEX_valid), .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
    .IDEX_rdata1(IDEX_rdata1), .IDEX_rdata2(IDEX_rdata2), .IDEX_imm(IDEX_imm),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemWrite(IDEX_MemWrite), .IDEX_MemtoReg(IDEX_MemtoReg),
    .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_RegDst(IDEX_RegDst), .IDEX_ALUOp(IDEX_ALUOp),
    .stall(stall), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lw $rt, imm($rs)
  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = 5'd0;
    id_uses_rs = 1'b1; id_uses_rt = 1'b0;
    id_rdata1 = 32'h1000; id_rdata2 = 32'h0; id_imm = imm;
    id_RegWrite = 1'b1; id_MemRead = 1'b1; id_MemWrite = 1'b0;
    id_MemtoReg = 1'b1; id_ALUSrc = 1'b1; id_RegDst = 1'b0; id_ALUOp = 2'b00;
  endtask

  // R-type add $rd, $rs, $rt
  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic urs, input logic urt);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt;
    id_rdata1 = 32'hA0A0_0000 | {27'd0, rs}; id_rdata2 = 32'hB0B0_0000 | {27'd0, rt};
    id_imm = 32'h0000_0020;
    id_RegWrite = 1'b1; id_MemRead = 1'b0; id_MemWrite = 1'b0;
    id_MemtoReg = 1'b0; id_ALUSrc = 1'b0; id_RegDst = 1'b1; id_ALUOp = 2'b10;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    drive_add(5'd8, 5'd9, 5'd10, 1'b1, 1'b1);

    // reset state
    #1;
    check("stall_in_rst", {31'd0, stall}, 32'd0);
    step();
    check("rst_valid", {31'd0, IDEX_valid}, 32'd0);
    check("rst_rs", {27'd0, IDEX_Rs}, 32'd0);
    check("rst_ctrl", {26'd0, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite,
                       IDEX_MemtoReg, IDEX_ALUSrc, IDEX_RegDst}, 32'd0);
    check("rst_cnts", {stall_count, flush_count}, 32'd0);

    // load-use hazard: lw $t0 then add using $t0
    rst = 1'b0;
    drive_lw(5'd9, 5'd8, 32'd4);
    #1 check("lw_no_stall", {31'd0, stall}, 32'd0);
    step();
    check("lw_loaded", {IDEX_valid, IDEX_MemRead, IDEX_MemtoReg, IDEX_ALUSrc, 23'd0, IDEX_Rt},
          {4'b1111, 23'd0, 5'd8});
    check("lw_imm", IDEX_imm, 32'd4);
    drive_add(5'd8, 5'd10, 5'd11, 1'b1, 1'b1);
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    step();
    check("lu_bubble", {IDEX_valid, IDEX_MemRead, IDEX_RegWrite, 24'd0, IDEX_Rs}, 32'd0);
    check("lu_scnt", {16'd0, stall_count}, 32'd1);
    check("lu_stall_drop", {31'd0, stall}, 32'd0);
    step();
    check("lu_add_rs", {IDEX_valid, IDEX_RegDst, 25'd0, IDEX_Rs}, {2'b11, 25'd0, 5'd8});
    check("lu_add_rd", {27'd0, IDEX_Rd}, 32'd11);
    check("lu_add_op", {30'd0, IDEX_ALUOp}, 32'd2);
    check("lu_add_d1", IDEX_rdata1, 32'hA0A0_0008);

    // $zero target never stalls
    drive_lw(5'd9, 5'd0, 32'd8);
    step();
    drive_add(5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
    #1 check("zero_no_stall", {31'd0, stall}, 32'd0);
    step();
    check("zero_loaded", {IDEX_valid, IDEX_RegWrite, 25'd0, IDEX_Rd}, {2'b11, 25'd0, 5'd12});

    // matching specifiers but no operand used
    drive_lw(5'd9, 5'd8, 32'd8);
    step();
    drive_add(5'd8, 5'd8, 5'd13, 1'b0, 1'b0);
    #1 check("nouse_no_stall", {31'd0, stall}, 32'd0);
    step();
    check("nouse_loaded", {27'd0, IDEX_Rd}, 32'd13);
    check("nouse_scnt", {16'd0, stall_count}, 32'd1);

    // rt-operand hazard also stalls
    drive_lw(5'd9, 5'd7, 32'd8);
    step();
    drive_add(5'd3, 5'd7, 5'd14, 1'b1, 1'b1);
    #1 check("rt_stall", {31'd0, stall}, 32'd1);
    step();
    check("rt_bubble", {31'd0, IDEX_valid}, 32'd0);

    // reset during the stall cycle
    drive_lw(5'd9, 5'd8, 32'd4);
    step();
    drive_add(5'd8, 5'd10, 5'd11, 1'b1, 1'b1);
    #1 check("rstmid_pre_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1 check("rstmid_stall0", {31'd0, stall}, 32'd0);
    step();
    check("rstmid_outs", {IDEX_valid, IDEX_MemRead, IDEX_RegWrite, IDEX_Rs, IDEX_Rt, IDEX_Rd},
          32'd0);
    check("rstmid_cnts", {stall_count, flush_count}, 32'd0);
    rst = 1'b0;
    #1 check("rstmid_no_stall", {31'd0, stall}, 32'd0);
    step();
    check("rstmid_add", {IDEX_valid, 26'd0, IDEX_Rs}, {1'b1, 26'd0, 5'd8});

    // flush beats stall
    drive_lw(5'd9, 5'd8, 32'd4);
    step();
    drive_add(5'd8, 5'd10, 5'd11, 1'b1, 1'b1);
    flush = 1'b1;
    #1 check("fl_stall0", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0;
    check("fl_bubble", {IDEX_valid, IDEX_MemRead, 25'd0, IDEX_Rt}, 32'd0);
    check("fl_cnts", {stall_count, flush_count}, {16'd0, 16'd1});

    // hold freezes the register for three cycles
    drive_add(5'd4, 5'd5, 5'd6, 1'b1, 1'b1);
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_add(5'd20 + 5'(i), 5'd21, 5'd22, 1'b1, 1'b1);
      step();
      check("hold_rs", {27'd0, IDEX_Rs}, 32'd4);
      check("hold_rd", {IDEX_valid, 26'd0, IDEX_Rd}, {1'b1, 26'd0, 5'd6});
    end
    hold = 1'b0;
    step();
    check("hold_release", {27'd0, IDEX_Rs}, 32'd22);
    check("hold_rel_d2", IDEX_rdata2, 32'hB0B0_0015);

    // flush with hold: flush wins and is counted
    flush = 1'b1; hold = 1'b1;
    #1 check("flhold_stall0", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0; hold = 1'b0;
    check("flhold_bubble", {31'd0, IDEX_valid}, 32'd0);
    check("flhold_fcnt", {16'd0, flush_count}, 32'd2);

    // invalid ID slot loads fields but zero controls
    drive_lw(5'd17, 5'd18, 32'd12);
    id_valid = 1'b0;
    step();
    check("inv_ctrl", {IDEX_valid, IDEX_RegWrite, IDEX_MemRead, IDEX_MemtoReg, IDEX_ALUSrc,
                       27'd0}, 32'd0);
    check("inv_rs", {27'd0, IDEX_Rs}, 32'd17);

    // stall counter saturation
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    for (int i = 0; i < 3; i++) begin
      drive_lw(5'd9, 5'd8, 32'd4);
      step();
      drive_add(5'd8, 5'd10, 5'd11, 1'b1, 1'b1);
      #1 check("sat_stall", {31'd0, stall}, 32'd1);
      step();
      check("sat_scnt", {16'd0, stall_count}, 32'h0000_FFFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
